fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of `maindec` and the rest of the decode logic. It holds the program counter, drives the instruction-memory address, and captures the returned instruction into an IF/ID register. It presents `Op_D` (instruction bits 31:21) to `maindec` one cycle after fetch. It supports stall, branch redirect with wrong-path flush, a fetch counter, and sticky misaligned-target detection.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 30 +++
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID payload type for the fetch stage and decode.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 21;

  // All-zero word decodes to all-zero control flags in maindec.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall; a flush keeps the old pc.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_flush,
  input  logic  i_stall,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q.instr <= NOP_INSTR;
      r_q.pc    <= '0;
      r_q.valid <= 1'b0;
    end else if (i_flush) begin
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID capture, fetch
// counter and sticky misaligned-branch-target flag.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N       = PC_W,
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output logic [10:0]        Op_D,
  output logic [31:0]        fetch_count,
  output logic               misalign_err
);

  logic [N-1:0] r_pc;
  logic [31:0]  r_fetch_count;
  logic         r_misalign_err;
  ifid_t        w_ifid_d;
  ifid_t        w_ifid_q;

  // Priority: reset > branch > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= '0;
      r_fetch_count  <= '0;
      r_misalign_err <= 1'b0;
    end else if (PCSrc_F) begin
      r_pc <= {PCBranch_F[N-1:2], 2'b00};
      if (PCBranch_F[1:0] != 2'b00)
        r_misalign_err <= 1'b1;
    end else if (!stall_F) begin
      r_pc          <= r_pc + N'(4);
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  always_comb begin
    w_ifid_d       = '0;
    w_ifid_d.instr = imem_data;
    w_ifid_d.pc    = r_pc;
    w_ifid_d.valid = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (PCSrc_F),
    .i_stall (stall_F),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_addr    = r_pc[IMEM_AW+1:2];
  assign instr_D      = w_ifid_q.instr;
  assign pc_D         = w_ifid_q.pc;
  assign valid_D      = w_ifid_q.valid;
  assign Op_D         = w_ifid_q.instr[OP_MSB:OP_LSB];
  assign fetch_count  = r_fetch_count;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational 64-word instruction ROM.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic [10:0] Op_D;
  logic [31:0] fetch_count;
  logic        misalign_err;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.N(64), .IMEM_AW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_F      (stall_F),
    .PCSrc_F      (PCSrc_F),
    .PCBranch_F   (PCBranch_F),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .valid_D      (valid_D),
    .Op_D         (Op_D),
    .fetch_count  (fetch_count),
    .misalign_err (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'hF840_0000;
    mem[1] = 32'hF800_0000;

    reset = 1'b1; stall_F = 1'b0; PCSrc_F = 1'b0; PCBranch_F = '0;
    step(); step();
    check("rst_valid", valid_D, 0);
    check("rst_instr", instr_D, 0);
    check("rst_pc_D", pc_D, 0);
    check("rst_count", fetch_count, 0);
    check("rst_err", misalign_err, 0);
    check("rst_addr", imem_addr, 0);

    // Free-run from reset release
    reset = 1'b0;
    step();
    check("run0_op", Op_D, 11'b111_1100_0010);
    check("run0_pc_D", pc_D, 0);
    check("run0_valid", valid_D, 1);
    check("run0_count", fetch_count, 1);
    check("run0_addr", imem_addr, 1);
    step();
    check("run1_op", Op_D, 11'b111_1100_0000);
    check("run1_pc_D", pc_D, 4);
    check("run1_count", fetch_count, 2);
    check("run1_addr", imem_addr, 2);

    // Stall three cycles at PC=8
    stall_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 2);
      check("stall_pc_D", pc_D, 4);
      check("stall_instr", instr_D, 32'hF800_0000);
      check("stall_count", fetch_count, 2);
      check("stall_valid", valid_D, 1);
    end
    stall_F = 1'b0;
    step();
    check("unstall_pc_D", pc_D, 8);
    check("unstall_instr", instr_D, 32'hA000_0002);
    check("unstall_count", fetch_count, 3);
    check("unstall_addr", imem_addr, 3);

    // Branch to 0x40 with simultaneous stall: branch wins
    stall_F = 1'b1; PCSrc_F = 1'b1; PCBranch_F = 64'h40;
    step();
    check("br_valid", valid_D, 0);
    check("br_instr", instr_D, 0);
    check("br_addr", imem_addr, 16);
    check("br_pc_D", pc_D, 8);
    check("br_count", fetch_count, 3);
    stall_F = 1'b0; PCSrc_F = 1'b0;
    step();
    check("brtgt_pc_D", pc_D, 64'h40);
    check("brtgt_valid", valid_D, 1);
    check("brtgt_instr", instr_D, 32'hA000_0010);
    check("brtgt_count", fetch_count, 4);
    check("brtgt_err", misalign_err, 0);

    // Misaligned target 0x42
    PCSrc_F = 1'b1; PCBranch_F = 64'h42;
    step();
    check("mis_addr", imem_addr, 16);
    check("mis_err", misalign_err, 1);
    check("mis_valid", valid_D, 0);
    check("mis_count", fetch_count, 4);
    PCSrc_F = 1'b0;
    step();
    check("mis_pc_D", pc_D, 64'h40);
    check("mis_count2", fetch_count, 5);

    // Aligned branch to word 63; flag must stay set, then wrap
    PCSrc_F = 1'b1; PCBranch_F = 64'hFC;
    step();
    check("sticky_err", misalign_err, 1);
    check("w63_addr", imem_addr, 63);
    PCSrc_F = 1'b0;
    step();
    check("wrap_pc_D", pc_D, 64'hFC);
    check("wrap_instr", instr_D, 32'hA000_003F);
    check("wrap_addr", imem_addr, 0);
    check("wrap_count", fetch_count, 6);
    check("wrap_err", misalign_err, 1);
    step();
    check("wrap2_pc_D", pc_D, 64'h100);
    check("wrap2_instr", instr_D, 32'hF840_0000);
    check("wrap2_count", fetch_count, 7);

    // Reset mid-run with stall and misaligned branch pending
    reset = 1'b1; stall_F = 1'b1; PCSrc_F = 1'b1; PCBranch_F = 64'h42;
    step();
    check("mrst_valid", valid_D, 0);
    check("mrst_instr", instr_D, 0);
    check("mrst_pc_D", pc_D, 0);
    check("mrst_count", fetch_count, 0);
    check("mrst_err", misalign_err, 0);
    check("mrst_addr", imem_addr, 0);
    reset = 1'b0; stall_F = 1'b0; PCSrc_F = 1'b0;
    step();
    check("restart_op", Op_D, 11'b111_1100_0010);
    check("restart_pc_D", pc_D, 0);
    check("restart_valid", valid_D, 1);
    check("restart_count", fetch_count, 1);
    check("restart_addr", imem_addr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
